// File: rtl/multicycle_controller_if.sv
// Controller <-> memory/datapath bundle: instruction/data memory handshakes plus gated control strobes.
interface multicycle_controller_if #(
  parameter int unsigned CNT_W = 32
);
  logic [6:0]       opcode;
  logic             imem_ack;
  logic             dmem_ack;
  logic             imem_req;
  logic             dmem_req;
  logic             IRWrite;
  logic             PCWrite;
  logic             MemWrite;
  logic             RegWrite;
  logic [3:0]       ALUSrc;
  logic [2:0]       MemtoReg;
  logic [4:0]       ALUControl;
  logic [2:0]       BranchControl;
  logic             retire;
  logic [CNT_W-1:0] retire_cnt;
  logic             trap;
  logic [1:0]       trap_cause;

  modport master (
    input  opcode, imem_ack, dmem_ack,
    output imem_req, dmem_req, IRWrite, PCWrite, MemWrite, RegWrite,
           ALUSrc, MemtoReg, ALUControl, BranchControl,
           retire, retire_cnt, trap, trap_cause
  );

  modport slave (
    output opcode, imem_ack, dmem_ack,
    input  imem_req, dmem_req, IRWrite, PCWrite, MemWrite, RegWrite,
           ALUSrc, MemtoReg, ALUControl, BranchControl,
           retire, retire_cnt, trap, trap_cause
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXECUTE/MEM/WRITEBACK with memory
// handshakes, bus-timeout and illegal-opcode traps, and a retired-instruction counter.
module multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter bit          EN_AUIPC    = 1'b1,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  multicycle_controller_if.master bus
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_t;

  state_t           state, state_d;
  logic [WAIT_W-1:0] wait_cnt, wait_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] retire_cnt_q;

  logic       legal_c, is_mem_c, is_store_c, is_branch_c;
  logic [3:0] alusrc_c;
  logic [2:0] memtoreg_c;
  logic [4:0] aluctl_c;
  logic [2:0] brctl_c;

  logic imem_req_c, dmem_req_c, irwrite_c, pcwrite_c, memwrite_c, regwrite_c, retire_c;
  logic bundle_en_c;

  // Opcode decode: control bundle plus instruction class flags for sequencing
  always_comb begin
    legal_c     = 1'b1;
    is_mem_c    = 1'b0;
    is_store_c  = 1'b0;
    is_branch_c = 1'b0;
    alusrc_c    = 4'b0000;
    memtoreg_c  = 3'b000;
    aluctl_c    = 5'b00000;
    brctl_c     = 3'b000;
    case (bus.opcode)
      OP_R:      begin alusrc_c = 4'b0001; memtoreg_c = 3'b001; aluctl_c = 5'b00001; end
      OP_I:      begin alusrc_c = 4'b0010; memtoreg_c = 3'b001; aluctl_c = 5'b00010; end
      OP_LOAD:   begin alusrc_c = 4'b0010; memtoreg_c = 3'b010; aluctl_c = 5'b00100;
                       is_mem_c = 1'b1; end
      OP_STORE:  begin alusrc_c = 4'b0100; aluctl_c = 5'b01000;
                       is_mem_c = 1'b1; is_store_c = 1'b1; end
      OP_BRANCH: begin alusrc_c = 4'b0001; brctl_c = 3'b001; is_branch_c = 1'b1; end
      OP_JAL:    begin memtoreg_c = 3'b100; brctl_c = 3'b100; end
      OP_JALR:   begin alusrc_c = 4'b0010; memtoreg_c = 3'b100; brctl_c = 3'b010; end
      OP_LUI:    begin alusrc_c = 4'b1000; memtoreg_c = 3'b001; aluctl_c = 5'b10000; end
      OP_AUIPC: begin
        if (EN_AUIPC) begin
          alusrc_c   = 4'b1000;
          memtoreg_c = 3'b001;
          aluctl_c   = 5'b10000;
        end else begin
          legal_c = 1'b0;
        end
      end
      default:   legal_c = 1'b0;
    endcase
  end

  // Next-state and strobe generation; wait counter tracks un-acked request cycles
  always_comb begin
    state_d    = state;
    wait_d     = wait_cnt;
    cause_d    = cause_q;
    imem_req_c = 1'b0;
    dmem_req_c = 1'b0;
    irwrite_c  = 1'b0;
    pcwrite_c  = 1'b0;
    memwrite_c = 1'b0;
    regwrite_c = 1'b0;
    retire_c   = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (bus.imem_ack) begin
          irwrite_c = 1'b1;
          wait_d    = '0;
          state_d   = S_DECODE;
        end else if (wait_cnt == WAIT_LAST) begin
          cause_d = 2'b10;
          state_d = S_TRAP;
        end else begin
          wait_d = wait_cnt + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        if (legal_c) begin
          state_d = S_EXECUTE;
        end else begin
          cause_d = 2'b01;
          state_d = S_TRAP;
        end
      end
      S_EXECUTE: begin
        if (is_mem_c) begin
          wait_d  = '0;
          state_d = S_MEM;
        end else if (is_branch_c) begin
          pcwrite_c = 1'b1;
          retire_c  = 1'b1;
          wait_d    = '0;
          state_d   = S_FETCH;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_MEM: begin
        dmem_req_c = 1'b1;
        memwrite_c = is_store_c;
        if (bus.dmem_ack) begin
          wait_d = '0;
          if (is_store_c) begin
            pcwrite_c = 1'b1;
            retire_c  = 1'b1;
            state_d   = S_FETCH;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          cause_d = 2'b11;
          state_d = S_TRAP;
        end else begin
          wait_d = wait_cnt + WAIT_W'(1);
        end
      end
      S_WRITEBACK: begin
        regwrite_c = 1'b1;
        pcwrite_c  = 1'b1;
        retire_c   = 1'b1;
        wait_d     = '0;
        state_d    = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_FETCH;
      wait_cnt     <= '0;
      cause_q      <= 2'b00;
      retire_cnt_q <= '0;
    end else begin
      state    <= state_d;
      wait_cnt <= wait_d;
      cause_q  <= cause_d;
      if (retire_c) retire_cnt_q <= retire_cnt_q + CNT_W'(1);
    end
  end

  // The fetch request is held off while reset is asserted even though state already reads FETCH
  assign bundle_en_c = (state == S_DECODE) || (state == S_EXECUTE) ||
                       (state == S_MEM)    || (state == S_WRITEBACK);

  assign bus.imem_req      = imem_req_c & rst_n;
  assign bus.IRWrite       = irwrite_c & rst_n;
  assign bus.dmem_req      = dmem_req_c;
  assign bus.PCWrite       = pcwrite_c;
  assign bus.MemWrite      = memwrite_c;
  assign bus.RegWrite      = regwrite_c;
  assign bus.retire        = retire_c;
  assign bus.ALUSrc        = bundle_en_c ? alusrc_c   : 4'b0000;
  assign bus.MemtoReg      = bundle_en_c ? memtoreg_c : 3'b000;
  assign bus.ALUControl    = bundle_en_c ? aluctl_c   : 5'b00000;
  assign bus.BranchControl = bundle_en_c ? brctl_c    : 3'b000;
  assign bus.retire_cnt    = retire_cnt_q;
  assign bus.trap          = (state == S_TRAP);
  assign bus.trap_cause    = cause_q;

endmodule
